// File: rtl/muldiv_seq_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit:
// FSM states, M-extension op encodings and the decoded op flags.
package muldiv_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [2:0] {
      OP_MUL    = F3_MUL,
      OP_MULH   = F3_MULH,
      OP_MULHSU = F3_MULHSU,
      OP_MULHU  = F3_MULHU,
      OP_DIV    = F3_DIV,
      OP_DIVU   = F3_DIVU,
      OP_REM    = F3_REM,
      OP_REMU   = F3_REMU
   } mdop_t;

   typedef struct packed {
      logic is_div;
      logic want_high;
      logic a_signed;
      logic b_signed;
      logic want_rem;
   } opflags_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
   logic             start;
   logic             kill;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (output start, kill, funct3, a, b, input busy, done, result);
   modport slave  (input start, kill, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_seq_opdec.sv
// Combinational decode of the M-extension funct3 into datapath control flags.
module muldiv_opdec
   import muldiv_pkg::*;
(
   input  logic [2:0] i_funct3,
   output opflags_t   o_flags
);

   // funct3 to operation flags
   always_comb begin
      o_flags = '0;
      case (mdop_t'(i_funct3))
         OP_MUL:    o_flags = '{is_div: 1'b0, want_high: 1'b0, a_signed: 1'b1, b_signed: 1'b1, want_rem: 1'b0};
         OP_MULH:   o_flags = '{is_div: 1'b0, want_high: 1'b1, a_signed: 1'b1, b_signed: 1'b1, want_rem: 1'b0};
         OP_MULHSU: o_flags = '{is_div: 1'b0, want_high: 1'b1, a_signed: 1'b1, b_signed: 1'b0, want_rem: 1'b0};
         OP_MULHU:  o_flags = '{is_div: 1'b0, want_high: 1'b1, a_signed: 1'b0, b_signed: 1'b0, want_rem: 1'b0};
         OP_DIV:    o_flags = '{is_div: 1'b1, want_high: 1'b0, a_signed: 1'b1, b_signed: 1'b1, want_rem: 1'b0};
         OP_DIVU:   o_flags = '{is_div: 1'b1, want_high: 1'b0, a_signed: 1'b0, b_signed: 1'b0, want_rem: 1'b0};
         OP_REM:    o_flags = '{is_div: 1'b1, want_high: 1'b0, a_signed: 1'b1, b_signed: 1'b1, want_rem: 1'b1};
         OP_REMU:   o_flags = '{is_div: 1'b1, want_high: 1'b0, a_signed: 1'b0, b_signed: 1'b0, want_rem: 1'b1};
         default:   o_flags = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// magnitudes, one bit per cycle, with sign fix-up and divide fast paths.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZEROS    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             r_state, w_state_nxt;
   opflags_t           w_dec;
   logic               r_is_div, r_want_high, r_want_rem, r_sign, r_fast;
   logic [2*WIDTH-1:0] r_acc, w_acc_nxt, w_prod;
   logic [WIDTH-1:0]   r_opnd;
   logic [CW-1:0]      r_cnt;
   logic               r_busy, r_done;
   logic [WIDTH-1:0]   r_result;

   logic               w_accept, w_finish, w_a_neg, w_b_neg, w_sign, w_div0, w_ovf;
   logic [WIDTH-1:0]   w_ma, w_mb, w_fast_val, w_trial, w_q_or_r, w_res;
   logic [WIDTH:0]     w_sum, w_rem_sh;
   logic               w_ge;

   muldiv_opdec u_opdec (.i_funct3(bus.funct3), .o_flags(w_dec));

   // Operand magnitudes, result sign and fast-path detection at the input
   always_comb begin
      w_a_neg    = w_dec.a_signed & bus.a[WIDTH-1];
      w_b_neg    = w_dec.b_signed & bus.b[WIDTH-1];
      w_ma       = w_a_neg ? (ZEROS - bus.a) : bus.a;
      w_mb       = w_b_neg ? (ZEROS - bus.b) : bus.b;
      w_sign     = w_dec.want_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
      w_div0     = w_dec.is_div & (bus.b == ZEROS);
      w_ovf      = w_dec.is_div & w_dec.a_signed & (bus.a == MOST_NEG) & (bus.b == ALL_ONES);
      w_fast_val = w_div0 ? (w_dec.want_rem ? bus.a : ALL_ONES)
                          : (w_dec.want_rem ? ZEROS : bus.a);
   end

   // One iteration: acc = {remainder, quotient} for divide, {partial, multiplier} for multiply
   always_comb begin
      w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
      w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_ge     = (w_rem_sh >= {1'b0, r_opnd});
      w_trial  = w_rem_sh[WIDTH-1:0] - r_opnd;
      if (r_is_div) begin
         w_acc_nxt = w_ge ? {w_trial, r_acc[WIDTH-2:0], 1'b1} : {r_acc[2*WIDTH-2:0], 1'b0};
      end else begin
         w_acc_nxt = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
      end
   end

   // Sign correction and output selection for the FIX state
   always_comb begin
      w_prod   = r_sign ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;
      w_q_or_r = r_want_rem ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
      if (r_fast) begin
         w_res = r_acc[WIDTH-1:0];
      end else if (r_is_div) begin
         w_res = r_sign ? (ZEROS - w_q_or_r) : w_q_or_r;
      end else if (r_want_high) begin
         w_res = w_prod[2*WIDTH-1:WIDTH];
      end else begin
         w_res = w_prod[WIDTH-1:0];
      end
   end

   // Next-state logic; kill overrides everything once an op is in flight
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start && !bus.kill) begin
               w_accept    = 1'b1;
               w_state_nxt = (w_div0 || w_ovf) ? S_FIX : S_CALC;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CALC: begin
            if (bus.kill) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CW'(1)) begin
               w_state_nxt = S_FIX;
            end else begin
               w_state_nxt = S_CALC;
            end
         end
         S_FIX: begin
            if (bus.kill) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_finish    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath, counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= {(2*WIDTH){1'b0}};
         r_opnd      <= ZEROS;
         r_cnt       <= {CW{1'b0}};
         r_is_div    <= 1'b0;
         r_want_high <= 1'b0;
         r_want_rem  <= 1'b0;
         r_sign      <= 1'b0;
         r_fast      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= ZEROS;
      end else begin
         r_busy <= (w_state_nxt != S_IDLE);
         r_done <= w_finish;
         if (w_accept) begin
            r_is_div    <= w_dec.is_div;
            r_want_high <= w_dec.want_high;
            r_want_rem  <= w_dec.want_rem;
            r_sign      <= w_sign;
            r_fast      <= w_div0 | w_ovf;
            r_cnt       <= CW'(WIDTH);
            if (w_div0 || w_ovf) begin
               r_acc <= {ZEROS, w_fast_val};
            end else begin
               r_acc <= {ZEROS, (w_dec.is_div ? w_ma : w_mb)};
            end
            r_opnd <= w_dec.is_div ? w_mb : w_ma;
         end else if (r_state == S_CALC) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_finish) begin
            r_result <= w_res;
         end
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;

endmodule
